// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries with single-cycle clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  assign head = mem[rd_ptr];

  // Entry storage; no reset needed since the head is qualified by count.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; clear empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      assert (!(push && !pop && (count == CW'(DEPTH))))
        else $error("fetch_fifo: push into full queue");
      assert (!(pop && (count == '0)))
        else $error("fetch_fifo: pop from empty queue");
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential requests
// against a credit limit, buffers responses and hands them to decode in order.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] kill_cnt;
  logic [CW-1:0] count;
  logic [SW-1:0] credits_used;
  logic [31:0]   target_pc;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Issue only while queued plus outstanding fetches leave room in the queue.
  assign credits_used   = SW'(count) + SW'(inflight);
  assign imem_req_valid = !rst && !redirect && (credits_used < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Stale responses from before a redirect are dropped while kill_cnt drains.
  assign rsp_drop   = imem_rsp_valid && (kill_cnt != '0);
  assign push       = imem_rsp_valid && (kill_cnt == '0) && !redirect;
  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_inst};

  assign out_valid = (count != '0);
  assign pop       = out_valid && !stall && !redirect;
  assign out_inst  = out_valid ? head.inst : NOP_INST;
  assign out_pc    = out_valid ? head.pc   : 32'h0000_0000;

  assign target_pc = redirect_pc & ~32'h0000_0003;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (redirect),
    .push_data (push_entry),
    .head      (head),
    .count     (count)
  );

  // PC and credit/kill bookkeeping; redirect has priority over normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      kill_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= target_pc;
      rsp_pc   <= target_pc;
      kill_cnt <= inflight - CW'(imem_rsp_valid);
      inflight <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (push)     rsp_pc   <= rsp_pc + 32'd4;
      if (rsp_drop) kill_cnt <= kill_cnt - CW'(1);
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

endmodule
